// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-wide big-endian data memory.
// One request in flight; sub-word stores use a read-modify-write.
module mem_access_unit #(
  parameter int unsigned DEPTH_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    RMW_WR,
    STORE_W,
    RESP
  } state_t;

  localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

  state_t      state;
  state_t      state_nxt;

  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [1:0]  sz;
  logic        bad_op;
  logic        misalign;
  logic        oor;
  logic        req_err;
  logic        accept;

  logic [31:0] waddr;
  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sgn;
  logic [31:0] load_val;
  logic [31:0] bmask;
  logic [31:0] hmask;
  logic [31:0] merged;

  // request classification, evaluated at acceptance
  always_comb begin
    sz       = req_op[1:0];
    accept   = req_valid && (state == IDLE);
    if (req_we)
      bad_op = (sz == 2'b11);
    else
      bad_op = (sz == 2'b11) || (req_op[2] && sz == 2'b10);
    misalign = ((sz == 2'b01) && req_addr[0]) ||
               ((sz == 2'b10) && (req_addr[1:0] != 2'b00));
    oor      = {req_addr[31:2], 2'b00} > LAST_WORD;
    req_err  = bad_op || misalign || oor;
  end

  // lane 0 sits in the top byte, so the shift is (3 - offset) * 8
  always_comb begin
    waddr  = {addr_q[31:2], 2'b00};
    bsh    = {~addr_q[1:0], 3'b000};
    hsh    = {~addr_q[1], 4'b0000};
    byte_v = 8'(mem_rdata >> bsh);
    half_v = 16'(mem_rdata >> hsh);
    load_val = mem_rdata;
    sgn      = 1'b0;
    case (op_q[1:0])
      2'b00: begin
        sgn      = byte_v[7] & ~op_q[2];
        load_val = {{24{sgn}}, byte_v};
      end
      2'b01: begin
        sgn      = half_v[15] & ~op_q[2];
        load_val = {{16{sgn}}, half_v};
      end
      default: load_val = mem_rdata;
    endcase
    bmask  = 32'h0000_00ff << bsh;
    hmask  = 32'h0000_ffff << hsh;
    if (op_q[1:0] == 2'b00)
      merged = (word_q & ~bmask) |
               ({24'b0, wdata_q[7:0]} << bsh);
    else
      merged = (word_q & ~hmask) |
               ({16'b0, wdata_q[15:0]} << hsh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state == LOAD)
        rdata_q <= load_val;
      if (state == RMW_RD)
        word_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)
            state_nxt = RESP;
          else if (!req_we)
            state_nxt = LOAD;
          else if (sz == 2'b10)
            state_nxt = STORE_W;
          else
            state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = RESP;
      RMW_RD:  state_nxt = RMW_WR;
      RMW_WR:  state_nxt = RESP;
      STORE_W: state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // enables drop during reset so an in-flight write never lands
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_err   = resp_valid && err_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      LOAD, RMW_RD: begin
        mem_read = !reset;
        mem_addr = waddr;
      end
      RMW_WR: begin
        mem_write = !reset;
        mem_addr  = waddr;
        mem_wdata = merged;
      end
      STORE_W: begin
        mem_write = !reset;
        mem_addr  = waddr;
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model,
// directed cases plus randomized load/store traffic.
module tb_mem_access_unit;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:DEPTH/4-1];
  logic [7:0]  rb  [0:DEPTH-1];

  int npass = 0;
  int ntot  = 0;
  int nrd   = 0;
  int nwr   = 0;
  int nboth = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH_BYTES(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_op(req_op),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_read) nrd++;
    if (mem_write) nwr++;
    if (mem_read && mem_write) nboth++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int nbytes(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_err(input logic we,
                                     input logic [2:0] op,
                                     input logic [31:0] a);
    longint base;
    logic bad;
    base = (longint'(a) / 4) * 4;
    if (we) bad = (op[1:0] == 2'b11);
    else bad = !(op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (op[1:0] == 2'b01 && (a % 2) != 0) bad = 1'b1;
    if (op[1:0] == 2'b10 && (a % 4) != 0) bad = 1'b1;
    if (base > DEPTH - 4) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] model_word(input int a);
    longint v = 0;
    for (int i = 0; i < 4; i++) v = v * 256 + rb[a + i];
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op,
                                             input logic [31:0] a);
    int n;
    longint v;
    n = nbytes(op);
    v = 0;
    for (int i = 0; i < n; i++) v = v * 256 + rb[int'(a) + i];
    if (!op[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] op,
                             input logic [31:0] a,
                             input logic [31:0] d);
    int n;
    n = nbytes(op);
    for (int i = 0; i < n; i++)
      rb[int'(a) + i] = 8'(d >> (8 * (n - 1 - i)));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".rvalid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".rdata"}, resp_rdata, 32'd0);
    chk({tag, ".rerr"}, 32'(resp_err), 32'd0);
    chk({tag, ".mrd"}, 32'(mem_read), 32'd0);
    chk({tag, ".mwr"}, 32'(mem_write), 32'd0);
    chk({tag, ".maddr"}, mem_addr, 32'd0);
    chk({tag, ".mwdata"}, mem_wdata, 32'd0);
  endtask

  task automatic run(input string tag,
                     input logic we,
                     input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input int hold,
                     output logic [31:0] got);
    logic e_err;
    logic [31:0] e_data;
    int e_lat, e_rd, e_wr, lat, rd0, wr0;
    e_err = model_err(we, op, a);
    e_data = 0;
    e_rd = 0;
    e_wr = 0;
    if (e_err) e_lat = 1;
    else if (!we) begin
      e_lat = 2; e_rd = 1;
      e_data = model_load(op, a);
    end else if (op[1:0] == 2'b10) begin
      e_lat = 2; e_wr = 1;
    end else begin
      e_lat = 3; e_rd = 1; e_wr = 1;
    end
    @(negedge clk);
    rd0 = nrd;
    wr0 = nwr;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = resp_rdata;
    chk({tag, ".lat"}, 32'(lat), 32'(e_lat));
    chk({tag, ".err"}, 32'(resp_err), 32'(e_err));
    chk({tag, ".data"}, resp_rdata, e_data);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hvalid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hdata"}, resp_rdata, e_data);
      chk({tag, ".hready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({tag, ".idle"}, 32'(req_ready), 32'd1);
    chk({tag, ".nrd"}, 32'(nrd - rd0), 32'(e_rd));
    chk({tag, ".nwr"}, 32'(nwr - wr0), 32'(e_wr));
    if (we && !e_err) model_store(op, a, d);
  endtask

  logic [31:0] got;
  logic [31:0] old;
  int wr0;

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_op     = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) rb[i] = 8'($urandom);
    rb[16] = 8'h88; rb[17] = 8'h99; rb[18] = 8'hAA; rb[19] = 8'hBB;
    for (int w = 0; w < DEPTH / 4; w++) mem[w] = model_word(4 * w);

    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst");
    reset = 1'b0;

    run("lb", 0, 3'b000, 32'h11, 0, 0, got);
    chk("lb.k", got, 32'hFFFFFF99);
    run("lbu", 0, 3'b100, 32'h11, 0, 0, got);
    chk("lbu.k", got, 32'h00000099);
    run("lh", 0, 3'b001, 32'h12, 0, 0, got);
    chk("lh.k", got, 32'hFFFFAABB);
    run("sb", 1, 3'b000, 32'h12, 32'h000000CC, 0, got);
    run("lw10", 0, 3'b010, 32'h10, 0, 0, got);
    chk("lw10.k", got, 32'h8899CCBB);
    run("sw", 1, 3'b010, 32'h20, 32'h12345678, 0, got);
    run("lw20", 0, 3'b010, 32'h20, 0, 0, got);
    chk("lw20.k", got, 32'h12345678);
    run("lhu", 0, 3'b101, 32'h22, 0, 0, got);
    chk("lhu.k", got, 32'h00005678);
    run("e_lw13", 0, 3'b010, 32'h13, 0, 0, got);
    run("e_sh11", 1, 3'b001, 32'h11, 32'hFFFF, 0, got);
    run("e_lw400", 0, 3'b010, 32'h400, 0, 0, got);
    run("e_op3", 0, 3'b011, 32'h0, 0, 0, got);
    run("e_sop3", 1, 3'b111, 32'h8, 32'h1, 0, got);
    run("lw3fc", 0, 3'b010, 32'h3FC, 0, 0, got);
    run("hold", 0, 3'b010, 32'h20, 0, 3, got);

    // reset during RMW_RD: the sub-word store must not land
    old = mem[12];
    wr0 = nwr;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b001;
    req_addr = 32'h30; req_wdata = 32'hBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_idle("rst_rmw");
    @(posedge clk);
    #1;
    chk("rst_rmw.nwr", 32'(nwr - wr0), 32'd0);
    chk("rst_rmw.mem", mem[12], old);
    chk("rst_rmw.model", mem[12], model_word(32'h30));

    // reset landing on the STORE_W cycle suppresses the write
    old = mem[13];
    wr0 = nwr;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010;
    req_addr = 32'h34; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_idle("rst_sw");
    chk("rst_sw.nwr", 32'(nwr - wr0), 32'd0);
    chk("rst_sw.mem", mem[13], old);

    for (int t = 0; t < 300; t++) begin
      logic        we;
      logic [2:0]  op;
      logic [31:0] a;
      we = 1'($urandom);
      op = 3'($urandom);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH + 15));
      run($sformatf("rnd%0d", t), we, op, a, $urandom,
          $urandom_range(0, 2), got);
    end

    for (int w = 0; w < DEPTH / 4; w++)
      chk($sformatf("final%0d", w), mem[w], model_word(4 * w));
    chk("rw_overlap", 32'(nboth), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit sitting directly upstream of the data memory. Accepts one memory request at a time from the execute stage over a valid/ready handshake. Drives the memory's word-wide, big-endian read/write port and performs alignment checks, byte/halfword extraction with sign/zero extension, and read-modify-write for sub-word stores. Returns the result on a response handshake.

## Interface
- DEPTH_BYTES, 1024: memory size in bytes; legal word base addresses are 0..DEPTH_BYTES-4.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use [1:0]: 00 SB, 01 SH, 10 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the sub-word is taken from LSBs
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  load result after extension; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal op
- mem_addr  out  32  word-aligned address to data memory
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable, sampled by memory on rising clk
- mem_wdata  out  32  word to write
- mem_rdata  in  32  combinational memory read data, valid in the same cycle mem_read=1

## Operation
- Big-endian lanes: byte offset 0 = bits [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]. Halfword offset 0 = [31:16], 2 = [15:0].
- A request is accepted when req_valid && req_ready. On acceptance, op, we, addr and wdata are registered.
- Error check at acceptance:
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - addr[31:2]*4 > DEPTH_BYTES-4 is an error.
  - Illegal op codes (load op 011/110/111, store op 11) are errors.
  - An error goes straight to RESP with resp_err=1 and resp_rdata=0. No mem_read or mem_write pulse is issued.
- States: IDLE, LOAD, RMW_RD, RMW_WR, STORE_W, RESP.
  - IDLE -> LOAD for a good load.
  - IDLE -> STORE_W for a good SW.
  - IDLE -> RMW_RD for a good SB/SH.
  - IDLE -> RESP on error.
  - LOAD: mem_read=1, mem_addr={addr[31:2],2'b00}. mem_rdata is extracted, extended and registered. Next state RESP.
  - RMW_RD: mem_read=1. The full word is registered. Next state RMW_WR.
  - RMW_WR: mem_write=1, mem_wdata = stored word with the addressed lane replaced by wdata[7:0] or wdata[15:0]. Next state RESP.
  - STORE_W: mem_write=1, mem_wdata=wdata. Next state RESP.
  - RESP: resp_valid=1. Go to IDLE when resp_ready=1.
- Sign extension: LB/LH replicate the selected MSB. LBU/LHU zero-fill.
- mem_read and mem_write are never high together. Both are 0 outside the states listed above. mem_addr and mem_wdata are 0 in IDLE and RESP.

## Timing
- Reset: state=IDLE. req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Latency from the acceptance edge to the first resp_valid cycle:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- resp_valid, resp_rdata and resp_err are held stable until accepted. The next request can be accepted in the cycle after the response handshake, since req_ready=0 until IDLE.
- req_valid may drop without penalty while req_ready=0. Inputs are ignored outside IDLE.
- Reset mid-operation takes effect at the next edge. If it is asserted during RMW_RD, no write occurs. A write already in RMW_WR/STORE_W at the same edge as reset is suppressed, because the enables are forced to 0 in the reset cycle's next state.
- Wrap: address arithmetic uses bits [31:2] only. There is no carry into byte lanes.

## Test plan
- Memory word 0x10 = 0x8899AABB. LB 0x11 -> resp_rdata=0xFFFFFF99. LBU 0x11 -> 0x00000099. LH 0x12 -> 0xFFFFAABB. Each has resp_valid exactly 2 cycles after acceptance.
- SB 0x12 with wdata=0x000000CC -> one mem_read cycle (addr 0x10), then one mem_write of 0x8899CCBB, resp_err=0. A following LW 0x10 returns 0x8899CCBB.
- SW 0x20 with 0x12345678, then LW 0x20 -> 0x12345678. LHU 0x22 -> 0x00005678.
- LW 0x13, SH 0x11, LW 0x400 and load op 011 -> each gives resp_err=1, resp_rdata=0, latency 1, and no mem_read/mem_write pulse.
- resp_ready held 0 for 3 cycles on a LW -> resp_valid and resp_rdata stay stable and req_ready=0. A new request is accepted only after the handshake.
- SH 0x30 with reset asserted while in RMW_RD -> no mem_write. All outputs return to their reset values. The word at 0x30 is unchanged.
